// File: rtl/argon_muldiv_unit.sv
// argon_muldiv_unit
// Iterative unsigned multiply / divide unit placed behind the Argon register
// file. A start request captures operands A/B, the opcode and the flags
// register, runs WORD_WIDTH shift-add (multiply) or restoring-divide
// iterations, then writes the result to register C and the updated flags to
// the flags register through the ALU write path.
//
// Configuration macro: ARGON_MULDIV_DIV_EN
//   defined   -> full DIVU/REMU support (restoring divider)
//   undefined -> divider removed; DIVU/REMU write 0 to C and flag DZ and Z
//
// Ports
//   i_Clk           clock, rising edge
//   i_Reset_n       asynchronous active-low reset
//   i_start         start request, sampled only while idle
//   i_op            0 MUL, 1 MULH, 2 DIVU, 3 REMU
//   i_reg_a         operand A (multiplicand / dividend)
//   i_reg_b         operand B (multiplier / divisor)
//   i_reg_flags     current flags register
//   o_busy          high while an operation is in flight (RUN, WB_C, WB_F)
//   o_done          one-cycle pulse during the flags write-back
//   o_write_data    registered write data toward the register file
//   o_write_select  registered write select: 1 = reg C, 2 = flags, 0 = none
module argon_muldiv_unit #(
   parameter int WORD_WIDTH = 16,
   parameter int Z_BIT      = 0,
   parameter int DZ_BIT     = 5
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset_n,
   input  logic                  i_start,
   input  logic [1:0]            i_op,
   input  logic [WORD_WIDTH-1:0] i_reg_a,
   input  logic [WORD_WIDTH-1:0] i_reg_b,
   input  logic [WORD_WIDTH-1:0] i_reg_flags,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [WORD_WIDTH-1:0] o_write_data,
   output logic [1:0]            o_write_select
);

   localparam logic [1:0] WSEL_NONE = 2'd0;
   localparam logic [1:0] WSEL_REGC = 2'd1;
   localparam logic [1:0] WSEL_REGF = 2'd2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_WB_C = 2'd2;
   localparam logic [1:0] S_WB_F = 2'd3;

   localparam int W = WORD_WIDTH;

   logic [1:0]     state;
   logic [4:0]     cnt;
   // Shared accumulator: multiply keeps {partial product, multiplier}, divide
   // keeps {partial remainder, dividend/quotient}.
   logic [2*W-1:0] acc;
   // Multiplicand for multiply, divisor for divide.
   logic [W-1:0]   opnd;
   logic [W-1:0]   flags;
   // Odd opcodes (MULH, REMU) take the upper half of the accumulator.
   logic           sel_hi;
   logic           dz;

   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [2*W-1:0] acc_next;
   logic [W-1:0]   result;
   logic [W-1:0]   flags_wb;

`ifdef ARGON_MULDIV_DIV_EN
   logic           is_div;
   logic [W:0]     div_shift;
   logic [W-1:0]   div_diff;
   logic [2*W-1:0] div_next;
`endif

   always_comb begin
      // Shift-add: add multiplicand into the high half when the current
      // multiplier LSB is set, then shift the whole register right.
      mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
      mul_next = {mul_sum, acc[W-1:1]};
`ifdef ARGON_MULDIV_DIV_EN
      // Restoring step: remainder shifted left with the next dividend MSB.
      // The difference fits in W bits whenever no borrow occurs, since the
      // incoming remainder is always below the divisor.
      div_shift = acc[2*W-1:W-1];
      div_diff  = div_shift[W-1:0] - opnd;
      if (div_shift >= {1'b0, opnd})
         div_next = {div_diff, acc[W-2:0], 1'b1};
      else
         div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      acc_next = is_div ? div_next : mul_next;
`else
      acc_next = mul_next;
`endif
      result = sel_hi ? acc_next[2*W-1:W] : acc_next[W-1:0];

      // During WB_C the output register holds the result just written.
      flags_wb         = flags;
      flags_wb[Z_BIT]  = (o_write_data == {W{1'b0}});
      flags_wb[DZ_BIT] = dz;
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state          <= S_IDLE;
         cnt            <= 5'd0;
         acc            <= '0;
         opnd           <= '0;
         flags          <= '0;
         sel_hi         <= 1'b0;
         dz             <= 1'b0;
`ifdef ARGON_MULDIV_DIV_EN
         is_div         <= 1'b0;
`endif
         o_write_data   <= '0;
         o_write_select <= WSEL_NONE;
      end else begin
         o_write_select <= WSEL_NONE;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  sel_hi <= i_op[0];
                  flags  <= i_reg_flags;
                  cnt    <= 5'd0;
                  dz     <= 1'b0;
                  if (!i_op[1]) begin
                     acc   <= {{W{1'b0}}, i_reg_b};
                     opnd  <= i_reg_a;
`ifdef ARGON_MULDIV_DIV_EN
                     is_div <= 1'b0;
`endif
                     state <= S_RUN;
`ifdef ARGON_MULDIV_DIV_EN
                  end else if (i_reg_b != {W{1'b0}}) begin
                     acc    <= {{W{1'b0}}, i_reg_a};
                     opnd   <= i_reg_b;
                     is_div <= 1'b1;
                     state  <= S_RUN;
                  end else begin
                     // Divide by zero: quotient all-ones, remainder = A.
                     dz             <= 1'b1;
                     o_write_data   <= i_op[0] ? i_reg_a : {W{1'b1}};
                     o_write_select <= WSEL_REGC;
                     state          <= S_WB_C;
                  end
`else
                  end else begin
                     // No divider built: report the opcode as illegal.
                     dz             <= 1'b1;
                     o_write_data   <= '0;
                     o_write_select <= WSEL_REGC;
                     state          <= S_WB_C;
                  end
`endif
               end
            end
            S_RUN: begin
               acc <= acc_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'(W - 1)) begin
                  cnt            <= 5'd0;
                  o_write_data   <= result;
                  o_write_select <= WSEL_REGC;
                  state          <= S_WB_C;
               end
            end
            S_WB_C: begin
               o_write_data   <= flags_wb;
               o_write_select <= WSEL_REGF;
               state          <= S_WB_F;
            end
            default: begin
               o_write_data <= '0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy = (state != S_IDLE);
   assign o_done = (state == S_WB_F);

endmodule

// File: tb/tb_argon_muldiv_unit.sv
// Self-checking bench for argon_muldiv_unit: directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_argon_muldiv_unit;
   localparam int W      = 16;
   localparam int Z_BIT  = 0;
   localparam int DZ_BIT = 5;
   localparam logic [1:0] WSEL_REGC = 2'd1;
   localparam logic [1:0] WSEL_REGF = 2'd2;

   logic         i_Clk = 1'b0;
   logic         i_Reset_n = 1'b0;
   logic         i_start = 1'b0;
   logic [1:0]   i_op = 2'd0;
   logic [W-1:0] i_reg_a = '0;
   logic [W-1:0] i_reg_b = '0;
   logic [W-1:0] i_reg_flags = '0;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_write_data;
   logic [1:0]   o_write_select;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   argon_muldiv_unit #(.WORD_WIDTH(W), .Z_BIT(Z_BIT), .DZ_BIT(DZ_BIT)) dut (
      .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_start(i_start), .i_op(i_op),
      .i_reg_a(i_reg_a), .i_reg_b(i_reg_b), .i_reg_flags(i_reg_flags),
      .o_busy(o_busy), .o_done(o_done), .o_write_data(o_write_data),
      .o_write_select(o_write_select)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned arithmetic straight from the opcode definitions.
   // lat = clock edges after the accepting edge until reg-C write is visible.
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic dz, output int lat);
      logic [2*W-1:0] p;
      p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      dz  = 1'b0;
      lat = W;
      case (op)
         2'd0: res = p[W-1:0];
         2'd1: res = p[2*W-1:W];
         default: begin
`ifdef ARGON_MULDIV_DIV_EN
            if (b == 0) begin
               dz  = 1'b1;
               lat = 0;
               res = (op == 2'd3) ? a : {W{1'b1}};
            end else begin
               res = (op == 2'd2) ? a / b : a % b;
            end
`else
            dz  = 1'b1;
            lat = 0;
            res = '0;
`endif
         end
      endcase
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] f, input bit glitch);
      logic [W-1:0] res;
      logic [W-1:0] ef;
      logic         dz;
      int           lat;
      int           n;
      int           extra;
      model(op, a, b, res, dz, lat);
      ef         = f;
      ef[Z_BIT]  = (res == 0);
      ef[DZ_BIT] = dz;

      @(negedge i_Clk);
      i_start = 1'b1; i_op = op; i_reg_a = a; i_reg_b = b; i_reg_flags = f;
      @(posedge i_Clk); #1;
      i_start = 1'b0;
      // Scramble inputs: the unit must use its captured copies.
      i_reg_a = W'($urandom); i_reg_b = W'($urandom); i_reg_flags = W'($urandom);
      check({tag, " busy"}, 32'(o_busy), 32'd1);

      n = 0;
      while (o_write_select !== WSEL_REGC && n < 3 * W) begin
         i_start = glitch && (n == 3 || n == 10);
         i_op    = 2'd2;
         i_reg_b = '0;
         @(posedge i_Clk); #1;
         n++;
      end
      i_start = 1'b0;
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " wb_c data"}, 32'(o_write_data), 32'(res));
      check({tag, " wb_c done"}, 32'(o_done), 32'd0);

      @(posedge i_Clk); #1;
      check({tag, " wb_f sel"}, 32'(o_write_select), 32'(WSEL_REGF));
      check({tag, " wb_f flags"}, 32'(o_write_data), 32'(ef));
      check({tag, " wb_f done"}, 32'(o_done), 32'd1);

      @(posedge i_Clk); #1;
      check({tag, " idle sel"}, 32'(o_write_select), 32'd0);
      check({tag, " idle busy"}, 32'(o_busy), 32'd0);

      if (glitch) begin
         extra = 0;
         repeat (25) begin
            @(posedge i_Clk); #1;
            if (o_done !== 1'b0 || o_busy !== 1'b0) extra++;
         end
         check({tag, " no queued start"}, 32'(extra), 32'd0);
      end
      $display("%s op=%0d a=0x%04h b=0x%04h expect res=0x%04h flags=0x%04h", tag, op, a, b, res, ef);
   endtask

   initial begin
      int seen;
      // Reset state
      #12;
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset done", 32'(o_done), 32'd0);
      check("reset data", 32'(o_write_data), 32'd0);
      check("reset sel", 32'(o_write_select), 32'd0);
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      repeat (2) @(posedge i_Clk);

      // Directed cases
      run_op("mul",      2'd0, 16'h0123, 16'h0010, 16'h00C2, 1'b0);
      run_op("mulh",     2'd1, 16'hFFFF, 16'hFFFF, 16'h00C2, 1'b0);
      run_op("mul_ff",   2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
      run_op("divu",     2'd2, 16'd100,  16'd7,    16'h0000, 1'b0);
      run_op("remu",     2'd3, 16'd100,  16'd7,    16'hFF00, 1'b0);
      run_op("remu_z",   2'd3, 16'd14,   16'd7,    16'h0021, 1'b0);
      run_op("divu_b0",  2'd2, 16'h1234, 16'h0000, 16'h00C2, 1'b0);
      run_op("remu_b0",  2'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0);
      run_op("mul_zero", 2'd0, 16'h0000, 16'hBEEF, 16'h8000, 1'b0);
      run_op("mul_glch", 2'd0, 16'h0123, 16'h0010, 16'h00C2, 1'b1);

      // Reset in the middle of RUN
      @(negedge i_Clk);
      i_start = 1'b1; i_op = 2'd0; i_reg_a = 16'h5555; i_reg_b = 16'h3333;
      @(posedge i_Clk); #1;
      i_start = 1'b0;
      repeat (8) @(posedge i_Clk);
      #2;
      i_Reset_n = 1'b0;
      #1;
      check("abort busy", 32'(o_busy), 32'd0);
      check("abort data", 32'(o_write_data), 32'd0);
      check("abort sel", 32'(o_write_select), 32'd0);
      seen = 0;
      repeat (4) begin
         @(posedge i_Clk); #1;
         if (o_write_select !== 2'd0 || o_done !== 1'b0) seen++;
      end
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      repeat (20) begin
         @(posedge i_Clk); #1;
         if (o_write_select !== 2'd0 || o_done !== 1'b0) seen++;
      end
      check("abort no write", 32'(seen), 32'd0);
      run_op("post_rst", 2'd0, 16'h0123, 16'h0010, 16'h00C2, 1'b0);

      // Random operations
      for (int i = 0; i < 20; i++) begin
         logic [1:0]   rop;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic [W-1:0] rf;
         rop = 2'($urandom_range(0, 3));
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, (i % 2) ? 255 : 65535));
         rf  = W'($urandom);
         run_op($sformatf("rnd%0d", i), rop, ra, rb, rf, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/argon_muldiv_unit.md
# argon_muldiv_unit

Iterative multiply/divide unit, one stage downstream of the Argon register file. It takes the A/B operand outputs and the flags register, runs a WORD_WIDTH-cycle shift-add multiply or restoring divide, and returns the result through the same write path the ALU uses: a write-data word plus a write select. It writes register C first, then the flags register, so the control unit only has to hold the ALU write-enable command while `o_busy` is high.

## Interface
- `WORD_WIDTH`, 16, operand/result width; must equal `word_t` width.
- `Z_BIT`, 0, flags bit written as zero-result flag.
- `DZ_BIT`, 5, flags bit written as divide-by-zero / illegal-op flag.
- `i_Clk`  in  1  clock, rising edge.
- `i_Reset_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_op`  in  2  0 MUL (low half), 1 MULH (high half, unsigned), 2 DIVU (quotient), 3 REMU (remainder).
- `i_reg_a`  in  WORD_WIDTH  operand A (dividend / multiplicand).
- `i_reg_b`  in  WORD_WIDTH  operand B (divisor / multiplier).
- `i_reg_flags`  in  WORD_WIDTH  current flags register.
- `o_busy`  out  1  high from the cycle after accepted start through WB_F inclusive.
- `o_done`  out  1  one-cycle pulse in WB_F.
- `o_write_data`  out  WORD_WIDTH  data to register file.
- `o_write_select`  out  `write_sel_t`  WSEL_REGC in WB_C, WSEL_REGF in WB_F, else 0 (no write).

## Operation
- States: IDLE, RUN, WB_C, WB_F.
- IDLE: on `i_start`, capture A, B, op, and flags into internal registers. Operands are not re-read after capture.
  - MUL/MULH: go to RUN.
  - DIVU/REMU with B≠0: go to RUN.
  - DIVU/REMU with B=0: go directly to WB_C. Quotient = all-ones, remainder = A, DZ set.
- RUN: 5-bit counter `cnt` runs 0..WORD_WIDTH-1, one iteration per cycle; after the last iteration go to WB_C.
  - Multiply: 2×WORD_WIDTH product register, shift-add, LSB of multiplier first.
  - Divide: restoring. Shift partial remainder left by 1, bring in next dividend MSB, subtract B. If no borrow, keep the difference and set the quotient bit; otherwise keep the old remainder.
- WB_C: `o_write_data` is the selected result (product[W-1:0], product[2W-1:W], quotient, or remainder); `o_write_select`=WSEL_REGC.
- WB_F: `o_write_data` is the captured flags with two bits replaced:
  - Z_BIT = (result==0).
  - DZ_BIT = divide-by-zero (or illegal op, see Configuration).
  - All other bits pass through unchanged.
  - `o_write_select`=WSEL_REGF; `o_done`=1; next state IDLE.
- `i_start` while not in IDLE is ignored. It is not queued.
- All arithmetic is unsigned with no overflow detection. MUL discards the high half; MULH discards the low half.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt`=0, all internal registers 0. Outputs: `o_busy`=0, `o_done`=0, `o_write_data`=0, `o_write_select`=0.
- Reset asserted mid-RUN or mid-WB aborts immediately. No write select is issued after reset.
- Start accepted on edge T. The unit is in RUN for edges T+1..T+W, WB_C occupies cycle T+W+1, and WB_F occupies T+W+2.
- Total latency from start to `o_done`: W+2 cycles (18 at W=16). Divide-by-zero: 2 cycles.
- `o_write_data` and `o_write_select` are registered outputs, valid for exactly one cycle each. The register file commits them on the same edge only if the bus command is the ALU write-enable command.
- `o_busy` falls on the edge leaving WB_F. A new start can be accepted the cycle after `o_done`.

## Configuration
- `ARGON_MULDIV_DIV_EN` defined: full behaviour as above.
- Undefined: the divider datapath is removed. DIVU/REMU go IDLE→WB_C directly, WB_C writes 0, and WB_F sets DZ_BIT (illegal op) and Z_BIT=1. Latency is 2 cycles. MUL/MULH are unchanged.

## Test plan
- MUL: A=0x0123, B=0x0010. Result: WB_C writes 0x1230 at cycle 17 after start; WB_F Z=0, DZ=0; other flag bits preserved from flags=0x00C2.
- MULH: A=B=0xFFFF. WB_C writes 0xFFFE. Repeat with MUL on the same operands: WB_C writes 0x0001.
- DIVU A=100, B=7: writes 0x000E. REMU A=100, B=7: writes 0x0002. REMU A=14, B=7: writes 0, Z=1.
- DIVU A=0x1234, B=0: WB_C writes 0xFFFF one cycle after start, DZ=1. REMU with the same operands writes 0x1234. With the macro undefined, DIVU A=100, B=7 writes 0 with DZ=1, Z=1.
- Pulse `i_start` again at cycles 3 and 10 of a MUL with different operands: the original result and the single `o_done` are unchanged.
- Assert `i_Reset_n`=0 at RUN cycle 8: outputs go to 0 immediately, no write select is issued; the next start completes normally.
